// File: rtl/lotr_pkg.sv
// Shared types for the ring-controller (rc) F2C path: request opcodes, the
// buffered request record, the responder FSM states and the request filter.
package lotr_pkg;

   typedef enum logic [1:0] {
      RD       = 2'd0,
      WR       = 2'd1,
      WR_BCAST = 2'd2,
      RD_RSP   = 2'd3
   } t_opcode;

   localparam logic [7:0] BCAST_ID = 8'hFF;

   typedef struct packed {
      t_opcode     opcode;
      logic [31:0] address;
      logic [31:0] data;
   } t_f2c_req;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_RD_DATA = 1'b1
   } t_rsp_state;

   // Unicast RD/WR must target this core; broadcast writes must carry BCAST_ID.
   function automatic logic reqIsLegal(input t_opcode op, input logic [7:0] tgt,
                                       input logic [7:0] coreId);
      logic ok;
      ok = 1'b0;
      case (op)
         RD, WR:   ok = (tgt == coreId);
         WR_BCAST: ok = (tgt == BCAST_ID);
         default:  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/f2c_responder_if.sv
// F2C request/response channels, the local data-memory port and the status
// flags of the responder. slave = the responder, master = rc plus memory side.
interface f2c_responder_if
   import lotr_pkg::*;
#(
   parameter int MEM_ADDR_W = 12
);
   logic                  F2C_ReqValidQ502H;
   t_opcode               F2C_ReqOpcodeQ502H;
   logic [31:0]           F2C_ReqAddressQ502H;
   logic [31:0]           F2C_ReqDataQ502H;
   logic                  MemReqQ503H;
   logic                  MemWrEnQ503H;
   logic [MEM_ADDR_W-1:0] MemAddressQ503H;
   logic [31:0]           MemWrDataQ503H;
   logic                  MemGntQ503H;
   logic [31:0]           MemRdDataQ504H;
   logic                  F2C_RspValidQ500H;
   t_opcode               F2C_RspOpcodeQ500H;
   logic [31:0]           F2C_RspAddressQ500H;
   logic [31:0]           F2C_RspDataQ500H;
   logic                  FifoFullQnnnH;
   logic                  OverflowErrQnnnH;
   logic                  IllegalReqQnnnH;

   modport slave (
      input  F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H, F2C_ReqDataQ502H,
      output MemReqQ503H, MemWrEnQ503H, MemAddressQ503H, MemWrDataQ503H,
      input  MemGntQ503H, MemRdDataQ504H,
      output F2C_RspValidQ500H, F2C_RspOpcodeQ500H, F2C_RspAddressQ500H, F2C_RspDataQ500H,
      output FifoFullQnnnH, OverflowErrQnnnH, IllegalReqQnnnH
   );

   modport master (
      output F2C_ReqValidQ502H, F2C_ReqOpcodeQ502H, F2C_ReqAddressQ502H, F2C_ReqDataQ502H,
      input  MemReqQ503H, MemWrEnQ503H, MemAddressQ503H, MemWrDataQ503H,
      output MemGntQ503H, MemRdDataQ504H,
      input  F2C_RspValidQ500H, F2C_RspOpcodeQ500H, F2C_RspAddressQ500H, F2C_RspDataQ500H,
      input  FifoFullQnnnH, OverflowErrQnnnH, IllegalReqQnnnH
   );
endinterface

// File: rtl/f2c_req_fifo.sv
// Request buffer: power-of-2 depth, show-ahead head, pointers wrap naturally.
// Reset only clears pointers/count; stale storage is never read while empty.
module f2c_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 66
) (
   input  logic                     clk,
   input  logic                     rstL,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wrData,
   output logic [WIDTH-1:0]         rdData,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] store_r [DEPTH];
   logic [PTR_W-1:0] wrPtr_r;
   logic [PTR_W-1:0] rdPtr_r;
   logic [CNT_W-1:0] count_r;

   // Storage write; no reset needed because occupancy is tracked by count_r.
   always_ff @(posedge clk) begin
      if (push) begin
         store_r[wrPtr_r] <= wrData;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rstL) begin
      if (!rstL) begin
         wrPtr_r <= '0;
         rdPtr_r <= '0;
         count_r <= '0;
      end else begin
         if (push) wrPtr_r <= wrPtr_r + PTR_W'(1);
         if (pop)  rdPtr_r <= rdPtr_r + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rdData = store_r[rdPtr_r];
   assign full   = (count_r == DEPTH_CNT);
   assign empty  = (count_r == '0);
   assign count  = count_r;
endmodule

// File: rtl/f2c_responder.sv
// Core-side F2C responder: filters rc requests, buffers them, executes them on
// the local data-memory port and returns RD_RSP for reads (one read in flight).
// Optional macro F2C_RESP_BYPASS_EN: an idle, empty block lets a legal request
// reach the memory port in its arrival cycle; if granted it is not buffered.
module f2c_responder
   import lotr_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MEM_ADDR_W = 12
) (
   input  logic             QClk,
   input  logic             RstQnnnL,
   input  logic [7:0]       CoreID,
   f2c_responder_if.slave   bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   t_rsp_state       state_r, stateNext_s;
   t_f2c_req         reqIn_s, fifoHead_s, memOp_s;
   logic             legalOp_s, reqLegal_s, bypassSel_s;
   logic             fifoFull_s, fifoEmpty_s, push_s, pop_s, drop_s;
   logic [CNT_W-1:0] fifoCount_s;
   logic             memReq_s, granted_s;
   logic [31:0]      rdAddr_r, rspAddr_r, rspData_r;
   logic             rspValid_r, illegal_r, overflow_r;
   t_opcode          rspOpcode_r;

   assign reqIn_s    = t_f2c_req'({bus.F2C_ReqOpcodeQ502H, bus.F2C_ReqAddressQ502H,
                                   bus.F2C_ReqDataQ502H});
   assign legalOp_s  = reqIsLegal(bus.F2C_ReqOpcodeQ502H, bus.F2C_ReqAddressQ502H[31:24], CoreID);
   assign reqLegal_s = bus.F2C_ReqValidQ502H & legalOp_s;

`ifdef F2C_RESP_BYPASS_EN
   assign bypassSel_s = reqLegal_s & fifoEmpty_s & (state_r == S_IDLE);
`else
   assign bypassSel_s = 1'b0;
`endif

   assign memOp_s   = bypassSel_s ? reqIn_s : fifoHead_s;
   assign memReq_s  = (state_r == S_IDLE) & (~fifoEmpty_s | bypassSel_s);
   assign granted_s = memReq_s & bus.MemGntQ503H;
   assign pop_s     = granted_s & ~bypassSel_s;
   // A granted bypass request has already executed, so it is not buffered.
   assign push_s    = reqLegal_s & (~fifoFull_s | pop_s) & ~(bypassSel_s & bus.MemGntQ503H);
   assign drop_s    = reqLegal_s & fifoFull_s & ~pop_s;

   f2c_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(t_f2c_req))
   ) u_fifo (
      .clk    (QClk),
      .rstL   (RstQnnnL),
      .push   (push_s),
      .pop    (pop_s),
      .wrData (reqIn_s),
      .rdData (fifoHead_s),
      .full   (fifoFull_s),
      .empty  (fifoEmpty_s),
      .count  (fifoCount_s)
   );

   // Next-state: only a granted read leaves S_IDLE, for the single data cycle.
   always_comb begin
      stateNext_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (granted_s && (memOp_s.opcode == RD)) begin
               stateNext_s = S_RD_DATA;
            end else begin
               stateNext_s = S_IDLE;
            end
         end
         S_RD_DATA: stateNext_s = S_IDLE;
         default:   stateNext_s = S_IDLE;
      endcase
   end

   // FSM state register and the address of the read in flight.
   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) begin
         state_r  <= S_IDLE;
         rdAddr_r <= '0;
      end else begin
         state_r <= stateNext_s;
         if (granted_s && (memOp_s.opcode == RD)) begin
            rdAddr_r <= memOp_s.address;
         end
      end
   end

   // Response flops and status flags (overflow is sticky until reset).
   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) begin
         rspValid_r  <= 1'b0;
         rspOpcode_r <= RD;
         rspAddr_r   <= '0;
         rspData_r   <= '0;
         illegal_r   <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         rspValid_r <= (state_r == S_RD_DATA);
         if (state_r == S_RD_DATA) begin
            rspOpcode_r <= RD_RSP;
            rspAddr_r   <= rdAddr_r;
            rspData_r   <= bus.MemRdDataQ504H;
         end else begin
            rspOpcode_r <= RD;
         end
         illegal_r  <= bus.F2C_ReqValidQ502H & ~legalOp_s;
         overflow_r <= overflow_r | drop_s;
      end
   end

   assign bus.MemReqQ503H         = memReq_s;
   assign bus.MemWrEnQ503H        = memReq_s & (memOp_s.opcode != RD);
   assign bus.MemAddressQ503H     = memReq_s ? memOp_s.address[MEM_ADDR_W+1:2] : '0;
   assign bus.MemWrDataQ503H      = memReq_s ? memOp_s.data : '0;
   assign bus.F2C_RspValidQ500H   = rspValid_r;
   assign bus.F2C_RspOpcodeQ500H  = rspOpcode_r;
   assign bus.F2C_RspAddressQ500H = rspAddr_r;
   assign bus.F2C_RspDataQ500H    = rspData_r;
   assign bus.FifoFullQnnnH       = (fifoCount_s == DEPTH_CNT);
   assign bus.OverflowErrQnnnH    = overflow_r;
   assign bus.IllegalReqQnnnH     = illegal_r;
endmodule
